fetch_unit: RTL and testbench

- Instruction-fetch (IF) stage of the 5-stage pipeline (IF -> ID -> EX -> MEM -> WB).
- Producer end of the instruction interface that the decode/control logic consumes.
- Generates the PC, issues requests to instruction memory, captures responses into the IF/ID register, and honours decode back-pressure and EX-stage branch/jump redirects.
- Single outstanding memory request.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/if_id_reg.sv | 53 +++++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: default width, NOP encoding, base opcodes and the fetch FSM states.
// Decode/control logic imports the same opcode values.
package riscv_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_DROP
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load beats consume; one cycle from load to visible output.
// Holds contents while decode is not consuming; the caller never loads into an occupied, non-draining slot.
module if_id_reg import riscv_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            consume,
  input  logic            flush,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc
);

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding request, response lands in IF/ID (memory latency + 1 cycles).
// Requests only when IF/ID is free or draining; EX redirects flush IF/ID and drop any in-flight response.
module fetch_unit import riscv_pkg::*; #(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_id_valid,
  output logic [31:0]     if_id_instr,
  output logic [XLEN-1:0] if_id_pc
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            slot_free, req_fire, rsp_load, consume;

  assign slot_free      = !if_id_valid || id_ready;
  assign imem_req_valid = !rst && (state_q == FETCH_REQ) && slot_free;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign consume        = if_id_valid && id_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    rsp_load = 1'b0;
    case (state_q)
      FETCH_REQ: begin
        if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          rsp_load = 1'b1;
          state_d  = FETCH_REQ;
        end
      end
      FETCH_DROP: begin
        if (imem_rsp_valid) state_d = FETCH_REQ;
      end
      default: state_d = FETCH_REQ;
    endcase

    // A redirect wins everywhere; an outstanding old-path request must be drained via FETCH_DROP.
    if (redirect_valid) begin
      pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
      rsp_load = 1'b0;
      if (state_q == FETCH_REQ) state_d = req_fire ? FETCH_DROP : FETCH_REQ;
      else                      state_d = imem_rsp_valid ? FETCH_REQ : FETCH_DROP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (rsp_load),
    .consume  (consume),
    .flush    (redirect_valid),
    .instr_in (imem_rsp_data),
    .pc_in    (req_pc_q),
    .valid    (if_id_valid),
    .instr    (if_id_instr),
    .pc       (if_id_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed per-cycle vectors for fetch_unit plus a 2-cycle-latency memory sequence.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b1;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc)
  );

  typedef struct {
    logic        rst, rdy, rsp_v;
    logic [31:0] rsp_d;
    logic        redir;
    logic [31:0] redir_pc;
    logic        id_rdy;
    logic        e_req_v;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vq[$];

  // Memory contents used by the bench: word at address a.
  function automatic logic [31:0] d(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  task automatic addv(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                      input logic rdr, input logic [31:0] rpc, input logic idr,
                      input logic erv, input logic [31:0] ea, input logic ev,
                      input logic [31:0] epc, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rsp_v = rv; v.rsp_d = rd; v.redir = rdr; v.redir_pc = rpc;
    v.id_rdy = idr; v.e_req_v = erv; v.e_addr = ea; v.e_v = ev; v.e_pc = epc; v.e_instr = ei;
    vq.push_back(v);
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic rdr, input logic [31:0] rpc, input logic idr);
    rst = r; imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rd;
    redirect_valid = rdr; redirect_pc = rpc; id_ready = idr;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic erv, input logic [31:0] ea,
                         input logic ev, input logic [31:0] epc, input logic [31:0] ei);
    chk({tag, " req_valid"}, 32'(imem_req_valid), 32'(erv));
    chk({tag, " req_addr"},  imem_req_addr, ea);
    chk({tag, " if_id_valid"}, 32'(if_id_valid), 32'(ev));
    chk({tag, " if_id_pc"},    if_id_pc, epc);
    chk({tag, " if_id_instr"}, if_id_instr, ei);
  endtask

  initial begin
    // Basic flow, 1-cycle memory, id_ready=1
    addv(1,0,0,0,           0,0,1,  0,32'h0,  0,32'h0,  NOP);
    addv(0,1,0,0,           0,0,1,  1,32'h0,  0,32'h0,  NOP);
    addv(0,1,1,d(32'h0),    0,0,1,  0,32'h4,  0,32'h0,  NOP);
    addv(0,1,0,0,           0,0,1,  1,32'h4,  1,32'h0,  d(32'h0));
    addv(0,1,1,d(32'h4),    0,0,1,  0,32'h8,  0,32'h0,  d(32'h0));
    // Decode stall for 5 cycles with 0x4 in IF/ID
    for (int i = 0; i < 5; i++)
      addv(0,1,0,0,         0,0,0,  0,32'h8,  1,32'h4,  d(32'h4));
    // Fetch of 0x8 resumes and is redirected to 0x100 in the same cycle
    addv(0,1,0,0,           1,32'h100,1, 1,32'h8, 1,32'h4, d(32'h4));
    addv(0,1,1,d(32'h8),    0,0,1,  0,32'h100, 0,32'h4, d(32'h4));
    addv(0,1,0,0,           0,0,1,  1,32'h100, 0,32'h4, d(32'h4));
    addv(0,1,1,d(32'h100),  0,0,1,  0,32'h104, 0,32'h4, d(32'h4));
    // Memory not ready for one cycle
    addv(0,0,0,0,           0,0,1,  1,32'h104, 1,32'h100, d(32'h100));
    addv(0,1,0,0,           0,0,1,  1,32'h104, 0,32'h100, d(32'h100));
    // Misaligned redirect together with the response
    addv(0,1,1,d(32'h104),  1,32'h203,1, 0,32'h108, 0,32'h100, d(32'h100));
    addv(0,1,0,0,           0,0,1,  1,32'h200, 0,32'h100, d(32'h100));
    addv(0,1,1,d(32'h200),  0,0,1,  0,32'h204, 0,32'h100, d(32'h100));
    addv(0,0,0,0,           0,0,0,  0,32'h204, 1,32'h200, d(32'h200));
    addv(0,1,0,0,           0,0,1,  1,32'h204, 1,32'h200, d(32'h200));
    // Redirect in WAIT without response, then again while dropping
    addv(0,1,0,0,           1,32'h300,1, 0,32'h208, 0,32'h200, d(32'h200));
    addv(0,1,0,0,           1,32'h400,1, 0,32'h300, 0,32'h200, d(32'h200));
    addv(0,1,1,d(32'h204),  0,0,1,  0,32'h400, 0,32'h200, d(32'h200));
    addv(0,1,0,0,           0,0,1,  1,32'h400, 0,32'h200, d(32'h200));
    // Reset in WAIT, response arrives during and just after reset
    addv(1,1,0,0,           0,0,1,  0,32'h404, 0,32'h200, d(32'h200));
    addv(1,1,1,d(32'h400),  0,0,1,  0,32'h0,   0,32'h0,   NOP);
    addv(0,0,1,d(32'h400),  0,0,1,  1,32'h0,   0,32'h0,   NOP);
    addv(0,0,0,0,           0,0,1,  1,32'h0,   0,32'h0,   NOP);
    // Redirect in REQ without handshake, then wrap at the top of the address space
    addv(0,0,0,0,           1,32'hFFFF_FFFC,1, 1,32'h0, 0,32'h0, NOP);
    addv(0,1,0,0,           0,0,1,  1,32'hFFFF_FFFC, 0,32'h0, NOP);
    addv(0,1,1,d(32'hFFFF_FFFC), 0,0,1, 0,32'h0, 0,32'h0, NOP);
    addv(0,1,0,0,           0,0,0,  0,32'h0, 1,32'hFFFF_FFFC, 32'h0FFF_FFFC);
    addv(0,1,0,0,           0,0,1,  1,32'h0, 1,32'hFFFF_FFFC, 32'h0FFF_FFFC);

    drive(1,0,0,0,0,0,1);
    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].rdy, vq[i].rsp_v, vq[i].rsp_d, vq[i].redir, vq[i].redir_pc, vq[i].id_rdy);
      #1;
      chk_all($sformatf("vec%0d", i), vq[i].e_req_v, vq[i].e_addr, vq[i].e_v, vq[i].e_pc, vq[i].e_instr);
    end

    // 2-cycle memory latency: valid appears 3 cycles after the handshake
    @(negedge clk); drive(1,0,0,0,0,0,1);
    @(negedge clk); drive(0,1,0,0,0,0,1); #1;
    chk_all("lat2 c0", 1, 32'h0, 0, 32'h0, NOP);
    @(negedge clk); drive(0,1,0,0,0,0,1); #1;
    chk_all("lat2 c1", 0, 32'h4, 0, 32'h0, NOP);
    @(negedge clk); drive(0,1,1,d(32'h0),0,0,1); #1;
    chk_all("lat2 c2", 0, 32'h4, 0, 32'h0, NOP);
    @(negedge clk); drive(0,1,0,0,0,0,1); #1;
    chk_all("lat2 c3", 1, 32'h4, 1, 32'h0, d(32'h0));

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
